spi_reg_ctrl: RTL



---
 rtl/spi_reg_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns the SPI slave shifter's byte stream into register-bus
// reads/writes. First byte of a frame is {rw, addr}; following bytes are write
// data or dummies clocked against read data, with the address auto-incrementing.
// Optional feature macro: SPI_REG_CTRL_STATUS_EN -- adds an 8-bit frame counter
// that is presented as the idle byte (shifted out during the next command byte).
module spi_reg_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_strobe,
  input  logic [WIDTH-1:0]  spi_rx,
  output logic [WIDTH-1:0]  spi_tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WIDTH-1:0]  reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [WIDTH-1:0]  reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, WR, RD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, stb_sync;
  logic                   cs_s, stb_s, cs_d, stb_d;
  logic                   byte_evt, frame_end;
  logic [ADDR_W-1:0]      addr, rx_addr;
  logic                   rd_d;
  logic [WIDTH-1:0]       idle_nxt;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign stb_s     = stb_sync[SYNC_STAGES-1];
  assign frame_end = cs_s & ~cs_d;
  assign rx_addr   = spi_rx[ADDR_W-1:0];

  // Synchronisers plus edge detect. cs resets to "selected" so a frame already
  // running at reset is held off in WAIT_CS instead of being half-decoded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync  <= '0;
      stb_sync <= '0;
      cs_d     <= 1'b0;
      stb_d    <= 1'b0;
      byte_evt <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], spi_strobe};
      cs_d     <= cs_s;
      stb_d    <= stb_s;
      byte_evt <= stb_s & ~stb_d;
    end
  end

`ifdef SPI_REG_CTRL_STATUS_EN
  logic [7:0] frame_cnt;
  logic [7:0] cnt_nxt;
  assign cnt_nxt = frame_cnt + 8'd1;

  // Idle byte loaded at frame end is the post-increment count, fitted to WIDTH.
  always_comb begin
    idle_nxt = '0;
    for (int i = 0; i < WIDTH && i < 8; i++) idle_nxt[i] = cnt_nxt[i];
  end
`else
  assign idle_nxt = '0;
`endif

  // Frame sequencer with registered bus strobes and shifter reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_CS;
      addr      <= '0;
      spi_tx    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      rd_d      <= 1'b0;
`ifdef SPI_REG_CTRL_STATUS_EN
      frame_cnt <= '0;
`endif
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      rd_d   <= reg_re;
      // Read data lands one cycle after reg_re; drop it if the frame already closed.
      if (rd_d && state == RD) spi_tx <= reg_rdata;
      case (state)
        WAIT_CS: if (cs_s) state <= IDLE;
        IDLE: begin
          if (!cs_s) begin
            state <= CMD;
            busy  <= 1'b1;
          end
        end
        CMD, WR, RD: begin
          if (byte_evt) begin
            if (state == CMD) begin
              if (spi_rx[WIDTH-1]) begin
                reg_re   <= 1'b1;
                reg_addr <= rx_addr;
                addr     <= rx_addr + ADDR_W'(1);
                state    <= RD;
              end else begin
                addr  <= rx_addr;
                state <= WR;
              end
            end else begin
              reg_addr <= addr;
              addr     <= addr + ADDR_W'(1);
              if (state == WR) begin
                reg_we    <= 1'b1;
                reg_wdata <= spi_rx;
              end else begin
                reg_re <= 1'b1;
              end
            end
          end
          // Frame end overrides the next-state above; any byte in the same
          // cycle has still issued its bus access.
          if (frame_end) begin
            state  <= IDLE;
            busy   <= 1'b0;
            spi_tx <= idle_nxt;
`ifdef SPI_REG_CTRL_STATUS_EN
            frame_cnt <= cnt_nxt;
`endif
          end
        end
        default: state <= WAIT_CS;
      endcase
    end
  end

endmodule
